// File: rtl/cnn_ofmap_streamer_pkg.sv
// cnn_ofmap_streamer_pkg: shared types, default geometry and helpers for the
// output feature-map streamer and its nested index counter.
package cnn_ofmap_streamer_pkg;

  // Default feature-map geometry, matching the cnn_topCore output stage.
  localparam int DEF_IN       = 1;
  localparam int DEF_OCH      = 3;
  localparam int DEF_OY       = 4;
  localparam int DEF_OX       = 4;
  localparam int DEF_DATA_LEN = 8;

  // Number of elements in one default-sized output frame.
  localparam int OFMAP_ELEMS  = DEF_IN * DEF_OCH * DEF_OY * DEF_OX;

  // Streamer control states.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } stream_state_e;

  // Counter width for a dimension of size n; a size-1 dimension still gets a
  // 1-bit field so every index port exists.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_ofmap_streamer_counter.sv
// cnn_nd_counter: four-level nested wrapping counter. Level 0 is the fastest
// and carries into level 1, then 2, then 3. Clear wins over enable.
module cnn_nd_counter
  import cnn_ofmap_streamer_pkg::*;
#(
  parameter int N3 = 1,
  parameter int N2 = 1,
  parameter int N1 = 1,
  parameter int N0 = 1,
  parameter int W3 = clog2_min1(N3),
  parameter int W2 = clog2_min1(N2),
  parameter int W1 = clog2_min1(N1),
  parameter int W0 = clog2_min1(N0)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [W3-1:0] cnt3,
  output logic [W2-1:0] cnt2,
  output logic [W1-1:0] cnt1,
  output logic [W0-1:0] cnt0,
  output logic          all_max
);

  logic [W3-1:0] cnt3_q, cnt3_d;
  logic [W2-1:0] cnt2_q, cnt2_d;
  logic [W1-1:0] cnt1_q, cnt1_d;
  logic [W0-1:0] cnt0_q, cnt0_d;
  logic          max3, max2, max1, max0;

  // Per-level wrap detection and the ripple-carry next-count computation.
  always_comb begin
    max3    = (cnt3_q == W3'(N3 - 1));
    max2    = (cnt2_q == W2'(N2 - 1));
    max1    = (cnt1_q == W1'(N1 - 1));
    max0    = (cnt0_q == W0'(N0 - 1));
    all_max = max3 & max2 & max1 & max0;
    cnt3_d  = cnt3_q;
    cnt2_d  = cnt2_q;
    cnt1_d  = cnt1_q;
    cnt0_d  = cnt0_q;
    if (clr) begin
      cnt3_d = '0;
      cnt2_d = '0;
      cnt1_d = '0;
      cnt0_d = '0;
    end else if (en) begin
      cnt0_d = max0 ? '0 : cnt0_q + W0'(1);
      if (max0) begin
        cnt1_d = max1 ? '0 : cnt1_q + W1'(1);
      end
      if (max0 && max1) begin
        cnt2_d = max2 ? '0 : cnt2_q + W2'(1);
      end
      if (max0 && max1 && max2) begin
        cnt3_d = max3 ? '0 : cnt3_q + W3'(1);
      end
    end
  end

  // Counter registers with synchronous reset to the origin.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt3_q <= '0;
      cnt2_q <= '0;
      cnt1_q <= '0;
      cnt0_q <= '0;
    end else begin
      cnt3_q <= cnt3_d;
      cnt2_q <= cnt2_d;
      cnt1_q <= cnt1_d;
      cnt0_q <= cnt0_d;
    end
  end

  assign cnt3 = cnt3_q;
  assign cnt2 = cnt2_q;
  assign cnt1 = cnt1_q;
  assign cnt0 = cnt0_q;

endmodule

// File: rtl/cnn_ofmap_streamer.sv
// cnn_ofmap_streamer: captures a flat output feature map on a one-cycle strobe
// and replays it one element per accepted valid/ready beat, tagged with its
// (in, och, oy, ox) coordinates and a last-beat marker.
module cnn_ofmap_streamer
  import cnn_ofmap_streamer_pkg::*;
#(
  parameter int IN       = DEF_IN,
  parameter int OCH      = DEF_OCH,
  parameter int OY       = DEF_OY,
  parameter int OX       = DEF_OX,
  parameter int DATA_LEN = DEF_DATA_LEN
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 i_in_valid,
  input  logic [IN*OCH*OY*OX*DATA_LEN-1:0]     i_in_fmap,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [DATA_LEN-1:0]                  o_data,
  output logic [clog2_min1(IN)-1:0]            o_idx_in,
  output logic [clog2_min1(OCH)-1:0]           o_idx_och,
  output logic [clog2_min1(OY)-1:0]            o_idx_oy,
  output logic [clog2_min1(OX)-1:0]            o_idx_ox,
  output logic                                 o_last,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_drop
);

  localparam int N      = IN * OCH * OY * OX;
  localparam int FMAP_W = N * DATA_LEN;
  localparam int SW     = clog2_min1(FMAP_W);

  stream_state_e       state_q, state_d;
  logic [FMAP_W-1:0]   shadow_q, shadow_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;
  logic                cnt_clr, cnt_en;
  logic                all_max;
  logic                streaming;
  logic                fire;
  logic [SW-1:0]       sel_base;

  // Coordinate counters: ox is the fastest level, in the slowest.
  cnn_nd_counter #(
    .N3(IN),
    .N2(OCH),
    .N1(OY),
    .N0(OX)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .cnt3   (o_idx_in),
    .cnt2   (o_idx_och),
    .cnt1   (o_idx_oy),
    .cnt0   (o_idx_ox),
    .all_max(all_max)
  );

  assign streaming = (state_q == ST_STREAM);
  assign fire      = streaming && i_ready;

  // Capture, advance, wrap and drop decisions for the next cycle.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    drop_d   = drop_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_in_valid) begin
          shadow_d = i_in_fmap;
          cnt_clr  = 1'b1;
          state_d  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (fire) begin
          cnt_en = 1'b1;
          if (all_max) begin
            done_d = 1'b1;
            if (i_in_valid) begin
              shadow_d = i_in_fmap;
              cnt_clr  = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (i_in_valid) begin
            drop_d = 1'b1;
          end
        end else if (i_in_valid) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, shadow frame and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
    end
  end

  // Element offset into the shadow frame, built only from the counters.
  always_comb begin
    sel_base = SW'((((int'(o_idx_in) * OCH + int'(o_idx_och)) * OY
                     + int'(o_idx_oy)) * OX + int'(o_idx_ox)) * DATA_LEN);
  end

  assign o_data  = shadow_q[sel_base +: DATA_LEN];
  assign o_valid = streaming;
  assign o_busy  = streaming;
  assign o_last  = streaming && all_max;
  assign o_done  = done_q;
  assign o_drop  = drop_q;

endmodule

// File: doc/cnn_ofmap_streamer.md
# cnn_ofmap_streamer

Downstream stage of `cnn_topCore`. It captures the flat output feature-map bus (`o_ot_fmap`) when `o_ot_valid` pulses, then emits it one `DATA_LEN`-bit element per accepted beat over a valid/ready stream, with coordinate tags and a last-beat marker. This decouples the wide parallel result from a narrow consumer such as a bus bridge, FIFO or memory writer.

## Interface
- `IN`, 1: number of input images (batch).
- `OCH`, 3: output channels.
- `OY`, 4: output rows.
- `OX`, 4: output columns.
- `DATA_LEN`, 8: element width in bits.

- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `i_in_valid`  in  1: one-cycle capture strobe; connect to `o_ot_valid`.
- `i_in_fmap`  in  `IN*OCH*OY*OX*DATA_LEN`: flat result bus; connect to `o_ot_fmap`.
- `o_valid`  out  1: a stream element is presented.
- `i_ready`  in  1: the consumer accepts the element.
- `o_data`  out  `DATA_LEN`: current element.
- `o_idx_in`, `o_idx_och`, `o_idx_oy`, `o_idx_ox`  out  `$clog2` of each dimension (minimum 1): coordinates of `o_data`.
- `o_last`  out  1: `o_data` is the final element of the frame.
- `o_busy`  out  1: a frame is held or is streaming.
- `o_done`  out  1: one-cycle pulse after the last beat is accepted.
- `o_drop`  out  1: sticky; a capture strobe was lost because the block was busy.

## Operation
- Element count `N = IN*OCH*OY*OX`.
- Element `e` occupies bits `[e*DATA_LEN +: DATA_LEN]`, where `e = in*OCH*OY*OX + och*OY*OX + oy*OX + ox`. This is the `cnn_topCore` output packing.
- Emission order: `ox` fastest, then `oy`, then `och`, then `in`. Element 0 goes first.
- FSM states:
  - `IDLE`: `o_valid`=0 and `o_busy`=0. When `i_in_valid`=1, latch `i_in_fmap` into a shadow register, zero all index counters and go to `STREAM`.
  - `STREAM`: `o_valid`=1 and `o_busy`=1. A beat transfers when `o_valid && i_ready`. On a transfer the nested counters advance (`ox` wraps to 0 and carries into `oy`, and so on up the order).
  - A transfer with `o_last`=1 goes to `IDLE` and sets `o_done`=1 for the next cycle.
- `o_data` and all `o_idx_*` are selected from the shadow register and counters only. There is no combinational path from `i_in_fmap`.
- `o_last` is 1 exactly when all counters are at their maximums.
- Stall: while `o_valid`=1 and `i_ready`=0, `o_data`, `o_idx_*` and `o_last` hold stable.
- Busy capture: `i_in_valid`=1 in `STREAM` without a last-beat transfer in the same cycle is ignored. The shadow register is unchanged and `o_drop` is set.
- Back-to-back capture: `i_in_valid`=1 in the same cycle as the last-beat transfer captures the new frame. The FSM stays in `STREAM` with counters reset to 0 and `o_done` still pulses. No drop is flagged.
- `N`=1: element 0 is also the last element (`o_last`=1 on the first beat).

## Timing
- Reset values: `o_valid`=0, `o_busy`=0, `o_last`=0, `o_done`=0, `o_drop`=0, `o_data`=0, all `o_idx_*`=0. FSM goes to `IDLE` and the shadow register clears to 0.
- Reset mid-stream: the frame is discarded; `o_valid`=0 on the cycle after reset is sampled. `o_done` is not pulsed.
- Capture latency: `i_in_valid` at edge k gives `o_valid`=1 with element 0 after edge k.
- Throughput: one element per cycle while `i_ready`=1. A full frame with `i_ready` held high needs N cycles after capture.
- `o_done` is asserted for exactly the one cycle after the final transfer edge.
- `o_drop` clears only on `reset`.

## Structure
- Shared include `defines_cnn_core.vh` provides `IN`, `OCH`, `OY`, `OX` and `DATA_LEN` as defaults. It also gets a new constant `OFMAP_ELEMS` = `IN*OCH*OY*OX` and the FSM state encodings `ST_IDLE`/`ST_STREAM`.
- One natural sub-module, `cnn_nd_counter`: a parameterised 4-level wrapping counter with enable, clear, per-level outputs and an `all_max` flag. It drives `o_idx_*` and `o_last`.
- Element select is an indexed part-select `shadow[e*DATA_LEN +: DATA_LEN]`, with `e` built from the counters.

## Test plan
- Defaults, `i_ready`=1 throughout, element e = e+1 (values 1..48): 48 consecutive beats with `o_data` 1..48, `o_idx_och`/`oy`/`ox` for beat 17 = (1,0,0), `o_last` only on beat 48, `o_done` one cycle later.
- Same frame, `i_ready` toggling 1,0,0,1,…: no element skipped or repeated; `o_data`/`o_idx_*` stable during every stall; 48 transfers total.
- Second `i_in_valid` at beat 10 with a different frame: stream continues 11..48 from the first frame, `o_drop`=1 and stays 1.
- `i_in_valid` coincident with the last-beat transfer, new frame value 0xA5 everywhere: next cycle `o_valid`=1, `o_data`=0xA5, all indices 0, `o_done`=1, `o_drop`=0.
- `reset` asserted at beat 20: next cycle `o_valid`=0, `o_busy`=0, all outputs 0; a fresh capture then restarts from element 0.
- Parameter override `IN`=`OCH`=`OY`=`OX`=1: a single beat with `o_last`=1 on the first cycle, then `o_done`.
